upgrade_spawn_ctrl: RTL and testbench
=====================================

// Module: upgrade_spawn_ctrl
// PURPOSE
//  Sequences the speed-upgrade pickup across its full life cycle: cooldown, spawn, live, grant, effect.
//  Places the pickup at a pseudo-random table position and exposes it to draw/collision logic.
//  Arbitrates fairly when both balls touch it in the same frame, then times the winner's speed boost.
//  Sits between the ball motion blocks (inputs: positions) and the speed/colour logic (outputs: boosts).
// PARAMETERS
//  COOLDOWN_FRAMES  120    frames hidden before each spawn (also after reset)
//  LIFETIME_FRAMES  600    frames pickup stays visible if uncollected
//  EFFECT_FRAMES    300    frames speed boost stays asserted for the winner
//  UPGRADE_SIZE     10'd4  half-width of pickup box, pixels
//  LFSR_SEED        8'hA5  LFSR reset value; must be non-zero
// PORTS
//  frame_clk        in   1   frame clock, one edge per video frame
//  Reset            in   1   reset
//  enable           in   1   game running; low freezes every counter and the FSM
//  BallX, BallY     in   10  ball 1 centre
//  Ball2X, Ball2Y   in   10  ball 2 centre
//  Ball_Size        in   10  ball half-width
//  upgrade_visible  out  1   pickup is drawn / collectable
//  UpgradeX, UpgradeY out 10 pickup centre
//  speed_1_active   out  1   ball 1 boost asserted
//  speed_2_active   out  1   ball 2 boost asserted
//  collected        out  1   one-frame pulse on grant
//  winner           out  1   0 = ball 1, 1 = ball 2; valid while boost asserted
// BEHAVIOUR
//  Reset Reset, asynchronous, active-high; clock frame_clk. All state registered on posedge frame_clk.
//  Reset values: state COOLDOWN, counter 0, all 1-bit outputs 0, UpgradeX/Y = POS_TABLE[0], last_idx 0, rr_pref 0, lfsr LFSR_SEED.
//  States: COOLDOWN -> ACTIVE -> EFFECT -> COOLDOWN; ACTIVE -> COOLDOWN on timeout.
//  COOLDOWN: counter increments. At count COOLDOWN_FRAMES-1: idx = lfsr[2:0].
//    If idx == last_idx, use idx+1 mod 8. Load UpgradeX/Y from table, set last_idx.
//    Same edge: counter to 0, upgrade_visible to 1, state to ACTIVE.
//  ACTIVE: hit_n = box overlap on both axes, inclusive, 11-bit unsigned math, no wrap:
//    Ball+Ball_Size >= Upg-UPGRADE_SIZE and Ball-Ball_Size <= Upg+UPGRADE_SIZE.
//    Lower bound clamps at 0 when Upg < UPGRADE_SIZE+Ball_Size.
//    Only hit_1: winner 0. Only hit_2: winner 1. Both: winner = rr_pref, then rr_pref toggles.
//    On any hit: visible 0, collected 1 for exactly one frame, speed_<winner>_active 1, counter 0, state EFFECT.
//    No hit at count LIFETIME_FRAMES-1: visible 0, counter 0, state COOLDOWN, no pulse.
//    Hit and timeout in the same frame: hit wins.
//  EFFECT: counter runs. At EFFECT_FRAMES-1: both speed outputs 0, counter 0, state COOLDOWN.
//    Collisions are ignored in EFFECT; at most one speed output is ever high.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps every enabled frame in all states.
//  enable low: FSM, counter and LFSR hold; collected forced 0; other outputs hold.
//  Reset mid-boost or mid-life: outputs drop asynchronously; sequence restarts with a full cooldown.
//  Counters are 16 bit; parameters must be >= 1 and < 65536.
// STRUCTURE
//  upgrade_pkg: typedef enum logic [1:0] {COOLDOWN, ACTIVE, EFFECT} upg_state_t;
//    POS_TABLE[8] of {x,y} 10-bit spawn points inside the 640x480 playfield; lfsr8_next() function.
//  Sub-module upgrade_hit_detect: combinational box test, instantiated once per ball.
//  FSM, counter, LFSR and arbiter stay in this module.
// TESTING (COOLDOWN=4, LIFETIME=6, EFFECT=5, UPGRADE_SIZE=4, Ball_Size=4)
//  1) Reset, balls far away.
//     -> visible rises on the 4th enabled edge; after 6 more edges it falls, with no collected pulse.
//  2) Spawn at (100,100); ball1 moved to (108,100) at frame 2 of ACTIVE.
//     -> collected one frame, speed_1_active high exactly 5 frames, winner 0.
//  3) Both balls at pickup centre, same frame.
//     -> ball1 wins. Repeat on the next spawn -> ball2 wins (rr_pref toggled).
//  4) Ball1 at (109,100), one pixel outside -> no hit.
//     Ball reaches the pickup on the last ACTIVE frame -> grant, not timeout.
//  5) Drop enable for 10 frames in mid-EFFECT -> boost stays high.
//     Remaining frame count is unchanged after enable returns; no spurious collected pulse.
//  6) Assert Reset during EFFECT -> speed outputs 0 immediately.
//     LFSR back to 8'hA5; next spawn exactly 4 frames after release.
//     Two consecutive spawns never share a table index.

Source files
------------

// File: rtl/upgrade_pkg.sv
// rtl/upgrade_pkg.sv - shared types, spawn table and LFSR step for the speed-upgrade pickup
//
// Purpose: state encoding, the fixed table of spawn points inside the 640x480
// playfield, and the 8-bit LFSR next-state function used to pick spawn points.
// Ports: none (package).

package upgrade_pkg;

  typedef enum logic [1:0] {
    COOLDOWN = 2'd0,
    ACTIVE   = 2'd1,
    EFFECT   = 2'd2
  } upg_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } upg_pos_t;

  // Spawn points, kept well inside the playfield so the pickup box never
  // touches the screen edge. All entries are distinct, so two different
  // indices always give two different positions.
  localparam upg_pos_t POS_TABLE [8] = '{
    '{x: 10'd320, y: 10'd240},
    '{x: 10'd540, y: 10'd100},
    '{x: 10'd100, y: 10'd100},
    '{x: 10'd100, y: 10'd380},
    '{x: 10'd540, y: 10'd380},
    '{x: 10'd200, y: 10'd160},
    '{x: 10'd440, y: 10'd320},
    '{x: 10'd320, y: 10'd60}
  };

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting left.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/upgrade_hit_detect.sv
// rtl/upgrade_hit_detect.sv - combinational ball-versus-pickup box overlap test
//
// Purpose: reports whether one ball's square box overlaps the pickup's box on
// both axes, edges inclusive. All arithmetic is 11-bit unsigned; differences
// that would go negative are clamped to 0 so nothing wraps.
// Ports:
//   i_ball_x, i_ball_y  in  10  ball centre
//   i_ball_size         in  10  ball half-width
//   i_upg_x, i_upg_y    in  10  pickup centre
//   o_hit               out  1  boxes overlap on both axes

module upgrade_hit_detect #(
  parameter logic [9:0] UPGRADE_SIZE = 10'd4
) (
  input  logic [9:0] i_ball_x,
  input  logic [9:0] i_ball_y,
  input  logic [9:0] i_ball_size,
  input  logic [9:0] i_upg_x,
  input  logic [9:0] i_upg_y,
  output logic       o_hit
);

  logic [10:0] w_ball_x_hi;
  logic [10:0] w_ball_x_lo;
  logic [10:0] w_ball_y_hi;
  logic [10:0] w_ball_y_lo;
  logic [10:0] w_upg_x_hi;
  logic [10:0] w_upg_x_lo;
  logic [10:0] w_upg_y_hi;
  logic [10:0] w_upg_y_lo;
  logic        w_hit_x;
  logic        w_hit_y;

  assign w_ball_x_hi = {1'b0, i_ball_x} + {1'b0, i_ball_size};
  assign w_ball_y_hi = {1'b0, i_ball_y} + {1'b0, i_ball_size};
  assign w_upg_x_hi  = {1'b0, i_upg_x} + {1'b0, UPGRADE_SIZE};
  assign w_upg_y_hi  = {1'b0, i_upg_y} + {1'b0, UPGRADE_SIZE};

  // Low edges clamp at 0 near the top/left border instead of wrapping.
  assign w_ball_x_lo = (i_ball_x >= i_ball_size) ? {1'b0, i_ball_x - i_ball_size} : 11'd0;
  assign w_ball_y_lo = (i_ball_y >= i_ball_size) ? {1'b0, i_ball_y - i_ball_size} : 11'd0;
  assign w_upg_x_lo  = (i_upg_x >= UPGRADE_SIZE) ? {1'b0, i_upg_x - UPGRADE_SIZE} : 11'd0;
  assign w_upg_y_lo  = (i_upg_y >= UPGRADE_SIZE) ? {1'b0, i_upg_y - UPGRADE_SIZE} : 11'd0;

  assign w_hit_x = (w_ball_x_hi >= w_upg_x_lo) && (w_ball_x_lo <= w_upg_x_hi);
  assign w_hit_y = (w_ball_y_hi >= w_upg_y_lo) && (w_ball_y_lo <= w_upg_y_hi);
  assign o_hit   = w_hit_x && w_hit_y;

endmodule

// File: rtl/upgrade_spawn_ctrl.sv
// rtl/upgrade_spawn_ctrl.sv - speed-upgrade pickup life cycle: cooldown, spawn, live, grant, effect
//
// Purpose: hides the pickup for a cooldown, spawns it at a pseudo-random table
// position (never the same index twice in a row), grants it to the touching
// ball (round-robin when both touch in the same frame), then times the boost.
// Ports:
//   frame_clk               in   1  one rising edge per video frame
//   Reset                   in   1  asynchronous, active-high
//   enable                  in   1  game running; low freezes FSM, counter, LFSR
//   BallX, BallY            in  10  ball 1 centre
//   Ball2X, Ball2Y          in  10  ball 2 centre
//   Ball_Size               in  10  ball half-width
//   upgrade_visible         out  1  pickup drawn / collectable
//   UpgradeX, UpgradeY      out 10  pickup centre
//   speed_1_active          out  1  ball 1 boost
//   speed_2_active          out  1  ball 2 boost
//   collected               out  1  one-frame pulse on grant
//   winner                  out  1  0 = ball 1, 1 = ball 2

module upgrade_spawn_ctrl
  import upgrade_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 120,
  parameter int unsigned LIFETIME_FRAMES = 600,
  parameter int unsigned EFFECT_FRAMES   = 300,
  parameter logic [9:0]  UPGRADE_SIZE    = 10'd4,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] Ball2X,
  input  logic [9:0] Ball2Y,
  input  logic [9:0] Ball_Size,
  output logic       upgrade_visible,
  output logic [9:0] UpgradeX,
  output logic [9:0] UpgradeY,
  output logic       speed_1_active,
  output logic       speed_2_active,
  output logic       collected,
  output logic       winner
);

  localparam logic [15:0] COOLDOWN_LAST = 16'(COOLDOWN_FRAMES - 1);
  localparam logic [15:0] LIFETIME_LAST = 16'(LIFETIME_FRAMES - 1);
  localparam logic [15:0] EFFECT_LAST   = 16'(EFFECT_FRAMES - 1);

  upg_state_t  r_state;
  logic [15:0] r_count;
  logic [7:0]  r_lfsr;
  logic [2:0]  r_last_idx;
  logic        r_rr_pref;
  logic        r_visible;
  logic [9:0]  r_upg_x;
  logic [9:0]  r_upg_y;
  logic        r_speed_1;
  logic        r_speed_2;
  logic        r_collected;
  logic        r_winner;

  upg_state_t  w_state_nxt;
  logic [15:0] w_count_nxt;
  logic [7:0]  w_lfsr_nxt;
  logic [2:0]  w_last_idx_nxt;
  logic        w_rr_pref_nxt;
  logic        w_visible_nxt;
  logic [9:0]  w_upg_x_nxt;
  logic [9:0]  w_upg_y_nxt;
  logic        w_speed_1_nxt;
  logic        w_speed_2_nxt;
  logic        w_collected_nxt;
  logic        w_winner_nxt;
  logic        w_grant_to_2;

  logic        w_hit_1;
  logic        w_hit_2;
  logic [2:0]  w_raw_idx;
  logic [2:0]  w_spawn_idx;

  upgrade_hit_detect #(.UPGRADE_SIZE(UPGRADE_SIZE)) u_hit_1 (
    .i_ball_x    (BallX),
    .i_ball_y    (BallY),
    .i_ball_size (Ball_Size),
    .i_upg_x     (r_upg_x),
    .i_upg_y     (r_upg_y),
    .o_hit       (w_hit_1)
  );

  upgrade_hit_detect #(.UPGRADE_SIZE(UPGRADE_SIZE)) u_hit_2 (
    .i_ball_x    (Ball2X),
    .i_ball_y    (Ball2Y),
    .i_ball_size (Ball_Size),
    .i_upg_x     (r_upg_x),
    .i_upg_y     (r_upg_y),
    .o_hit       (w_hit_2)
  );

  // Skip forward one slot (3-bit wrap = mod 8) if the LFSR repeats the last
  // index, so consecutive spawns always move.
  assign w_raw_idx   = r_lfsr[2:0];
  assign w_spawn_idx = (w_raw_idx == r_last_idx) ? w_raw_idx + 3'd1 : w_raw_idx;

  // Ties go to the preferred ball; a single toucher always wins outright.
  assign w_grant_to_2 = (w_hit_1 && w_hit_2) ? r_rr_pref : w_hit_2;

  assign w_lfsr_nxt = enable ? lfsr8_next(r_lfsr) : r_lfsr;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= COOLDOWN;
      r_count     <= 16'd0;
      r_lfsr      <= LFSR_SEED;
      r_last_idx  <= 3'd0;
      r_rr_pref   <= 1'b0;
      r_visible   <= 1'b0;
      r_upg_x     <= POS_TABLE[0].x;
      r_upg_y     <= POS_TABLE[0].y;
      r_speed_1   <= 1'b0;
      r_speed_2   <= 1'b0;
      r_collected <= 1'b0;
      r_winner    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_rr_pref   <= w_rr_pref_nxt;
      r_visible   <= w_visible_nxt;
      r_upg_x     <= w_upg_x_nxt;
      r_upg_y     <= w_upg_y_nxt;
      r_speed_1   <= w_speed_1_nxt;
      r_speed_2   <= w_speed_2_nxt;
      r_collected <= w_collected_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  // Everything holds by default; collected is a pulse so it defaults low,
  // which also keeps it low through any frames with enable deasserted.
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_last_idx_nxt  = r_last_idx;
    w_rr_pref_nxt   = r_rr_pref;
    w_visible_nxt   = r_visible;
    w_upg_x_nxt     = r_upg_x;
    w_upg_y_nxt     = r_upg_y;
    w_speed_1_nxt   = r_speed_1;
    w_speed_2_nxt   = r_speed_2;
    w_collected_nxt = 1'b0;
    w_winner_nxt    = r_winner;

    if (enable) begin
      case (r_state)
        COOLDOWN: begin
          if (r_count == COOLDOWN_LAST) begin
            w_count_nxt    = 16'd0;
            w_visible_nxt  = 1'b1;
            w_last_idx_nxt = w_spawn_idx;
            w_upg_x_nxt    = POS_TABLE[w_spawn_idx].x;
            w_upg_y_nxt    = POS_TABLE[w_spawn_idx].y;
            w_state_nxt    = ACTIVE;
          end else begin
            w_count_nxt = r_count + 16'd1;
          end
        end

        ACTIVE: begin
          // A touch on the final live frame still counts as a grant.
          if (w_hit_1 || w_hit_2) begin
            if (w_hit_1 && w_hit_2) begin
              w_rr_pref_nxt = ~r_rr_pref;
            end
            w_winner_nxt    = w_grant_to_2;
            w_speed_1_nxt   = ~w_grant_to_2;
            w_speed_2_nxt   = w_grant_to_2;
            w_visible_nxt   = 1'b0;
            w_collected_nxt = 1'b1;
            w_count_nxt     = 16'd0;
            w_state_nxt     = EFFECT;
          end else if (r_count == LIFETIME_LAST) begin
            w_visible_nxt = 1'b0;
            w_count_nxt   = 16'd0;
            w_state_nxt   = COOLDOWN;
          end else begin
            w_count_nxt = r_count + 16'd1;
          end
        end

        EFFECT: begin
          if (r_count == EFFECT_LAST) begin
            w_speed_1_nxt = 1'b0;
            w_speed_2_nxt = 1'b0;
            w_count_nxt   = 16'd0;
            w_state_nxt   = COOLDOWN;
          end else begin
            w_count_nxt = r_count + 16'd1;
          end
        end

        default: begin
          w_count_nxt = 16'd0;
          w_state_nxt = COOLDOWN;
        end
      endcase
    end
  end

  assign upgrade_visible = r_visible;
  assign UpgradeX        = r_upg_x;
  assign UpgradeY        = r_upg_y;
  assign speed_1_active  = r_speed_1;
  assign speed_2_active  = r_speed_2;
  assign collected       = r_collected;
  assign winner          = r_winner;

endmodule

// File: tb/tb_upgrade_spawn_ctrl.sv
// tb/tb_upgrade_spawn_ctrl.sv - scoreboard bench for upgrade_spawn_ctrl

module tb_upgrade_spawn_ctrl;

  localparam int CD = 4;
  localparam int LT = 6;
  localparam int EF = 5;
  localparam int US = 4;

  localparam int EV_SPAWN   = 0;
  localparam int EV_GRANT   = 1;
  localparam int EV_TIMEOUT = 2;
  localparam int EV_END     = 3;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       enable    = 1'b0;
  logic [9:0] BallX, BallY, Ball2X, Ball2Y, Ball_Size;
  logic       upgrade_visible;
  logic [9:0] UpgradeX, UpgradeY;
  logic       speed_1_active, speed_2_active, collected, winner;

  always #5 frame_clk = ~frame_clk;

  upgrade_spawn_ctrl #(
    .COOLDOWN_FRAMES (CD),
    .LIFETIME_FRAMES (LT),
    .EFFECT_FRAMES   (EF),
    .UPGRADE_SIZE    (10'd4),
    .LFSR_SEED       (8'hA5)
  ) dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .enable          (enable),
    .BallX           (BallX),
    .BallY           (BallY),
    .Ball2X          (Ball2X),
    .Ball2Y          (Ball2Y),
    .Ball_Size       (Ball_Size),
    .upgrade_visible (upgrade_visible),
    .UpgradeX        (UpgradeX),
    .UpgradeY        (UpgradeY),
    .speed_1_active  (speed_1_active),
    .speed_2_active  (speed_2_active),
    .collected       (collected),
    .winner          (winner)
  );

  typedef struct {
    int kind;
    int frame;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  frame_no = 0;

  int tab_x[8] = '{320, 540, 100, 100, 540, 200, 440, 320};
  int tab_y[8] = '{240, 100, 100, 380, 380, 160, 320, 60};

  // Reference model: phase 0 hidden, 1 live, 2 boosting; m_left = frames to go.
  int         m_phase, m_left, m_last, m_rr, m_x, m_y;
  logic [7:0] m_lfsr;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit touches(input int bx, input int by, input int bs);
    return (iabs(bx - m_x) <= bs + US) && (iabs(by - m_y) <= bs + US);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (frame %0d)", name, act, req, frame_no);
    end
  endtask

  task automatic push(input int kind, input int a, input int b);
    exp_q.push_back('{kind, frame_no + 1, a, b});
  endtask

  task automatic obs(input int kind, input int a, input int b);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d data %0d/%0d at frame %0d, required none",
               kind, a, b, frame_no);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.frame != frame_no || e.a != a || e.b != b) begin
        n_errors++;
        $display("FAIL event: got kind %0d frame %0d data %0d/%0d, required kind %0d frame %0d data %0d/%0d",
                 kind, frame_no, a, b, e.kind, e.frame, e.a, e.b);
      end
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_left  = CD;
    m_lfsr  = 8'hA5;
    m_last  = 0;
    m_rr    = 0;
    m_x     = tab_x[0];
    m_y     = tab_y[0];
  endtask

  // Predict the coming edge from the current inputs, then take it.
  task automatic step();
    logic [7:0] cur;
    int  idx, w;
    bit  h1, h2;
    if (enable) begin
      cur    = m_lfsr;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      case (m_phase)
        0: begin
          m_left--;
          if (m_left == 0) begin
            idx = int'(cur[2:0]);
            if (idx == m_last) idx = (idx + 1) % 8;
            m_last  = idx;
            m_x     = tab_x[idx];
            m_y     = tab_y[idx];
            m_phase = 1;
            m_left  = LT;
            push(EV_SPAWN, m_x, m_y);
          end
        end
        1: begin
          h1 = touches(int'(BallX), int'(BallY), int'(Ball_Size));
          h2 = touches(int'(Ball2X), int'(Ball2Y), int'(Ball_Size));
          if (h1 || h2) begin
            w = (h1 && h2) ? m_rr : (h2 ? 1 : 0);
            if (h1 && h2) m_rr = 1 - m_rr;
            push(EV_GRANT, w, w ? 2 : 1);
            m_phase = 2;
            m_left  = EF;
          end else begin
            m_left--;
            if (m_left == 0) begin
              push(EV_TIMEOUT, 0, 0);
              m_phase = 0;
              m_left  = CD;
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            push(EV_END, 0, 0);
            m_phase = 0;
            m_left  = CD;
          end
        end
      endcase
    end
    @(posedge frame_clk);
    frame_no++;
    @(negedge frame_clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("reset_visible", int'(upgrade_visible), 0);
    chk("reset_speed_1", int'(speed_1_active), 0);
    chk("reset_speed_2", int'(speed_2_active), 0);
    chk("reset_collected", int'(collected), 0);
    model_reset();
    @(negedge frame_clk);
    #2;
    Reset = 1'b0;
  endtask

  task automatic far();
    BallX     = 10'd5;
    BallY     = 10'd470;
    Ball2X    = 10'd630;
    Ball2Y    = 10'd470;
    Ball_Size = 10'd4;
    enable    = 1'b1;
  endtask

  task automatic both_at_centre();
    BallX  = 10'(m_x);
    BallY  = 10'(m_y);
    Ball2X = 10'(m_x);
    Ball2Y = 10'(m_y);
  endtask

  task automatic run_to_live();
    for (int i = 0; i < 50 && m_phase != 1; i++) step();
    chk("reached_live", m_phase, 1);
  endtask

  // Monitor: turns DUT output transitions into events and scores them.
  int p_vis = 0, p_s1 = 0, p_s2 = 0;
  int have_last = 0, last_x = 0, last_y = 0;

  always @(negedge frame_clk) begin
    if (Reset) begin
      p_vis = 0; p_s1 = 0; p_s2 = 0; have_last = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].frame < frame_no) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_event: kind %0d due frame %0d, not observed by frame %0d",
                 exp_q[0].kind, exp_q[0].frame, frame_no);
        void'(exp_q.pop_front());
      end
      chk("one_boost", int'(speed_1_active & speed_2_active), 0);
      if (collected) begin
        obs(EV_GRANT, int'(winner), int'({upgrade_visible, speed_2_active, speed_1_active}));
      end else if (upgrade_visible && p_vis == 0) begin
        obs(EV_SPAWN, int'(UpgradeX), int'(UpgradeY));
        if (have_last != 0)
          chk("new_position", int'(int'(UpgradeX) == last_x && int'(UpgradeY) == last_y), 0);
        have_last = 1;
        last_x    = int'(UpgradeX);
        last_y    = int'(UpgradeY);
      end else if (!upgrade_visible && p_vis != 0) begin
        obs(EV_TIMEOUT, 0, 0);
      end else if (!speed_1_active && !speed_2_active && (p_s1 != 0 || p_s2 != 0)) begin
        obs(EV_END, 0, 0);
      end
      p_vis = int'(upgrade_visible);
      p_s1  = int'(speed_1_active);
      p_s2  = int'(speed_2_active);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r;
    far();
    do_reset();
    chk("reset_upg_x", int'(UpgradeX), 320);
    chk("reset_upg_y", int'(UpgradeY), 240);

    // 1) spawn after cooldown, then timeout with no pulse
    repeat (CD + LT) step();
    chk("s1_hidden_after_timeout", int'(upgrade_visible), 0);

    // 2) ball 1 reaches pickup on the second live frame
    far(); do_reset();
    repeat (CD + 1) step();
    BallX = 10'(m_x + 8); BallY = 10'(m_y);
    step();
    far();
    repeat (EF) step();

    // 3) simultaneous touches alternate between the balls
    far(); do_reset();
    run_to_live();
    both_at_centre();
    step();
    far();
    run_to_live();
    both_at_centre();
    step();
    far();
    repeat (EF + 1) step();

    // 4) one pixel outside does not hit; hit on the last live frame wins over timeout
    far(); do_reset();
    run_to_live();
    BallX = 10'(m_x + 9); BallY = 10'(m_y);
    repeat (LT - 1) step();
    BallX = 10'(m_x + 8);
    step();
    far();
    repeat (EF) step();

    // 5) enable low mid-boost freezes the remaining boost time
    far(); do_reset();
    run_to_live();
    BallX = 10'(m_x); BallY = 10'(m_y);
    step();
    far();
    repeat (2) step();
    enable = 1'b0;
    repeat (10) step();
    chk("s5_boost_held", int'(speed_1_active), 1);
    enable = 1'b1;
    repeat (EF - 2) step();

    // 6) reset during boost, then a clean full cooldown
    far(); do_reset();
    run_to_live();
    BallX = 10'(m_x); BallY = 10'(m_y);
    step();
    far();
    repeat (2) step();
    do_reset();
    repeat (CD + 2) step();

    // Random play
    far(); do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      enable    = ($urandom_range(0, 9) != 0);
      Ball_Size = 10'($urandom_range(0, 8));
      r = int'(Ball_Size) + US + 2;
      if ($urandom_range(0, 2) == 0) begin
        BallX = 10'(m_x + int'($urandom_range(0, 2 * r)) - r);
        BallY = 10'(m_y + int'($urandom_range(0, 2 * r)) - r);
      end else begin
        BallX = 10'd5; BallY = 10'd470;
      end
      if ($urandom_range(0, 2) == 0) begin
        Ball2X = 10'(m_x + int'($urandom_range(0, 2 * r)) - r);
        Ball2Y = 10'(m_y + int'($urandom_range(0, 2 * r)) - r);
      end else begin
        Ball2X = 10'd630; Ball2Y = 10'd470;
      end
      step();
    end
    enable = 1'b1;
    far();
    step();
    step();

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
